// File: rtl/pll_pkg.sv
// Shared types and constants for the PLL clock-enable generator.
// Holds the reset FSM state type and the per-channel parameter extraction helper.
package pll_pkg;

  localparam int ACC_WIDTH_DEF = 16;
  localparam int MAX_CHANNELS  = 8;
  localparam int MAX_ACC_WIDTH = 32;
  localparam int PACK_W        = MAX_CHANNELS * MAX_ACC_WIDTH;

  typedef enum logic [1:0] {
    ST_HOLD  = 2'd0,
    ST_COUNT = 2'd1,
    ST_RUN   = 2'd2
  } rst_state_t;

  // Pull field idx (each width bits wide) out of a zero-extended packed vector.
  function automatic int unsigned chan_field(input logic [PACK_W-1:0] vec,
                                             input int idx, input int width);
    logic [PACK_W-1:0] sh;
    logic [31:0]       mask;
    logic [31:0]       res;
    sh   = vec >> (idx * width);
    mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    res  = sh[31:0] & mask;
    return res;
  endfunction

endpackage

// File: rtl/frac_cen.sv
// One fractional clock-enable channel: accumulator divider producing NUM
// registered one-cycle pulses per DEN enabled cycles.
module frac_cen
  import pll_pkg::*;
#(
  parameter int          ACC_WIDTH = ACC_WIDTH_DEF,
  parameter int unsigned NUM       = 1,
  parameter int unsigned DEN       = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic cen
);

  localparam logic [ACC_WIDTH:0] NUM_W = (ACC_WIDTH + 1)'(NUM);
  localparam logic [ACC_WIDTH:0] DEN_W = (ACC_WIDTH + 1)'(DEN);

  if ((NUM == 0) || (NUM > DEN) || ((64'(DEN) >> ACC_WIDTH) != 64'd0)) begin : g_bad_ratio
    $error("frac_cen: illegal NUM/DEN for ACC_WIDTH");
  end

  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH:0]   sum;
  logic [ACC_WIDTH:0]   diff;
  logic                 hit;

  always_comb begin
    sum  = {1'b0, acc} + NUM_W;
    diff = sum - DEN_W;
    hit  = (sum >= DEN_W);
  end

  // clr dominates en: a channel held in reset restarts from phase zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (clr) begin
      acc <= '0;
      cen <= 1'b0;
    end else if (!en) begin
      cen <= 1'b0;
    end else begin
      cen <= hit;
      acc <= hit ? diff[ACC_WIDTH-1:0] : sum[ACC_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/pll_cen_gen.sv
// Lock-qualified system reset plus NUM_CHANNELS fractional clock-enable strobes,
// all strobes gated and re-phased whenever the system reset is asserted.
module pll_cen_gen
  import pll_pkg::*;
#(
  parameter int                                NUM_CHANNELS = 4,
  parameter int                                ACC_WIDTH    = ACC_WIDTH_DEF,
  parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] CEN_NUM      = {16'd1, 16'd1, 16'd1, 16'd5},
  parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0] CEN_DEN      = {16'd8, 16'd8, 16'd4, 16'd12},
  parameter int                                LOCK_DELAY   = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    locked,
  input  logic                    pause,
  output logic                    reset_out,
  output logic [NUM_CHANNELS-1:0] cen,
  output logic                    lock_lost,
  output rst_state_t              fsm_state
);

  localparam int CNT_W = $clog2(LOCK_DELAY);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_DELAY - 1);
  localparam logic [PACK_W-1:0] NUM_EXT = PACK_W'(CEN_NUM);
  localparam logic [PACK_W-1:0] DEN_EXT = PACK_W'(CEN_DEN);

  if ((NUM_CHANNELS < 1) || (NUM_CHANNELS > MAX_CHANNELS) || (LOCK_DELAY < 2) ||
      (ACC_WIDTH < 1) || (ACC_WIDTH > MAX_ACC_WIDTH)) begin : g_bad_cfg
    $error("pll_cen_gen: illegal configuration");
  end

  logic             sync1;
  logic             lk_s;
  rst_state_t       state;
  rst_state_t       state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             lost_evt;
  logic             clr;
  logic             en;

  assign fsm_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk_s  <= 1'b0;
    end else begin
      sync1 <= locked;
      lk_s  <= sync1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    lost_evt  = 1'b0;
    case (state)
      ST_HOLD: begin
        if (lk_s) state_nxt = ST_COUNT;
      end
      ST_COUNT: begin
        if (!lk_s)                 state_nxt = ST_HOLD;
        else if (cnt == CNT_LAST)  state_nxt = ST_RUN;
        else                       cnt_nxt   = cnt + 1'b1;
      end
      ST_RUN: begin
        if (!lk_s) begin
          state_nxt = ST_HOLD;
          lost_evt  = 1'b1;
        end
      end
      default: state_nxt = ST_HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_HOLD;
      cnt       <= '0;
      reset_out <= 1'b1;
      lock_lost <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      reset_out <= (state_nxt != ST_RUN);
      lock_lost <= lock_lost | lost_evt;
    end
  end

  // Clearing on the edge that re-asserts reset_out keeps cen low from that edge on.
  assign clr = reset_out | (state_nxt != ST_RUN);
  assign en  = ~pause;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    frac_cen #(
      .ACC_WIDTH(ACC_WIDTH),
      .NUM      (chan_field(NUM_EXT, i, ACC_WIDTH)),
      .DEN      (chan_field(DEN_EXT, i, ACC_WIDTH))
    ) u_ch (
      .clk(clk),
      .rst(rst),
      .clr(clr),
      .en (en),
      .cen(cen[i])
    );
  end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed bench for pll_cen_gen: per-cycle expected {reset_out, lock_lost, cen}
// entries are queued by the driver and popped/compared by a negedge monitor.
module tb_pll_cen_gen;
  import pll_pkg::*;

  localparam int NCH = 4;
  localparam int LD  = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             locked;
  logic             pause;
  logic             reset_out;
  logic [NCH-1:0]   cen;
  logic             lock_lost;
  rst_state_t       fsm_state;

  always #5 clk = ~clk;

  // Channel map: ch0 1/8, ch1 1/8, ch2 1/4, ch3 5/12.
  pll_cen_gen #(
    .NUM_CHANNELS(NCH),
    .ACC_WIDTH   (16),
    .CEN_NUM     ({16'd5, 16'd1, 16'd1, 16'd1}),
    .CEN_DEN     ({16'd12, 16'd4, 16'd8, 16'd8}),
    .LOCK_DELAY  (LD)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .locked   (locked),
    .pause    (pause),
    .reset_out(reset_out),
    .cen      (cen),
    .lock_lost(lock_lost),
    .fsm_state(fsm_state)
  );

  logic [5:0] exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  int         pc[NCH];
  bit         prev_rst_exp;
  bit         lost_exp;
  int         e;
  // 5/12 pulse pattern, bit k = enabled cycle k+1: 0,0,1,0,1,0,0,1,0,1,0,1
  logic [11:0] ch3_pat = 12'b1010_1001_0100;

  function automatic logic [3:0] cen_pat(input int idx);
    logic [3:0] r;
    r[0] = (idx % 8) == 0;
    r[1] = (idx % 8) == 0;
    r[2] = (idx % 4) == 0;
    r[3] = ch3_pat[(idx - 1) % 12];
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, expv);
    end
  endtask

  // One clock edge; exp_rst is the reset_out value expected after it.
  task automatic cyc(input bit exp_rst);
    logic [3:0] c;
    @(posedge clk);
    c = 4'b0;
    if (!prev_rst_exp && !exp_rst && !pause) begin
      e++;
      c = cen_pat(e);
    end
    if (exp_rst) e = 0;
    prev_rst_exp = exp_rst;
    exp_q.push_back({exp_rst, lost_exp, c});
    #1;
  endtask

  task automatic clear_counts();
    for (int i = 0; i < NCH; i++) pc[i] = 0;
  endtask

  always @(negedge clk) begin
    logic [5:0] x;
    if (!rst && exp_q.size() > 0) begin
      x = exp_q.pop_front();
      check("cyc", 32'({reset_out, lock_lost, cen}), 32'(x));
      for (int i = 0; i < NCH; i++) if (cen[i]) pc[i]++;
    end
  end

  initial begin
    rst = 1'b1; locked = 1'b0; pause = 1'b0;
    prev_rst_exp = 1'b1; lost_exp = 1'b0; e = 0;
    clear_counts();
    #12;
    check("rst_reset_out", 32'(reset_out), 32'd1);
    check("rst_cen", 32'(cen), 32'd0);
    check("rst_lock_lost", 32'(lock_lost), 32'd0);
    check("rst_state", 32'(fsm_state), 32'(ST_HOLD));
    @(posedge clk); #1 rst = 1'b0;

    // Lock-up: 2 sync edges, 1 HOLD exit edge, LD COUNT edges.
    repeat (10) cyc(1'b1);
    locked = 1'b1;
    repeat (LD + 2) cyc(1'b1);
    cyc(1'b0);

    // Integer and fractional rates.
    clear_counts();
    repeat (96) cyc(1'b0);
    @(negedge clk); #1;
    check("ch0_96", 32'(pc[0]), 32'd12);
    check("ch2_96", 32'(pc[2]), 32'd24);
    repeat (384) cyc(1'b0);
    @(negedge clk); #1;
    check("ch3_480", 32'(pc[3]), 32'd200);
    check("ch0_480", 32'(pc[0]), 32'd60);
    check("ch1_480", 32'(pc[1]), 32'd60);

    // Pause 5 cycles mid-period on ch3 (just before its pulse at index 3).
    repeat (2) cyc(1'b0);
    pause = 1'b1;
    repeat (5) cyc(1'b0);
    pause = 1'b0;
    repeat (30) cyc(1'b0);

    // Lock loss in RUN for 4 cycles; reset_out rises on the third edge.
    locked = 1'b0;
    cyc(1'b0);
    cyc(1'b0);
    lost_exp = 1'b1;
    cyc(1'b1);
    cyc(1'b1);
    locked = 1'b1;
    repeat (LD + 2) cyc(1'b1);
    cyc(1'b0);
    clear_counts();
    repeat (24) cyc(1'b0);
    @(negedge clk); #1;
    check("relock_ch0", 32'(pc[0]), 32'd3);
    check("relock_ch2", 32'(pc[2]), 32'd6);
    check("relock_ch3", 32'(pc[3]), 32'd10);

    // Asynchronous reset mid-run clears everything, including the sticky flag.
    rst = 1'b1;
    #1;
    check("arst_reset_out", 32'(reset_out), 32'd1);
    check("arst_cen", 32'(cen), 32'd0);
    check("arst_lock_lost", 32'(lock_lost), 32'd0);
    lost_exp = 1'b0; prev_rst_exp = 1'b1; e = 0;

    // Glitch in COUNT: counter reaches 10 after edge 13, locked low for 4 edges.
    @(posedge clk); #1 rst = 1'b0;
    repeat (13) cyc(1'b1);
    locked = 1'b0;
    repeat (4) cyc(1'b1);
    locked = 1'b1;
    repeat (LD + 2) cyc(1'b1);
    cyc(1'b0);
    repeat (12) cyc(1'b0);

    @(negedge clk); #1;
    check("q_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
